// File: rtl/ber_counter_if.sv
// Bundles the BER counter's strobe, reference and control inputs with its result outputs.
// master drives the inputs (slicer/PRBS/register-file side); slave is the counter itself.
// Widths follow the counter and latency widths of the attached instance.
interface ber_counter_if #(
  parameter int NB_CNT = 64,
  parameter int NB_LAT = 9
);
  logic              i_enb;
  logic              i_rx_bit;
  logic              i_ref_bit;
  logic              i_run;
  logic              i_clr;
  logic [NB_CNT-1:0] o_ber_samp;
  logic [NB_CNT-1:0] o_ber_error;
  logic [NB_LAT-1:0] o_latency;
  logic              o_aligned;
  logic              o_searching;

  modport master (
    output i_enb, i_rx_bit, i_ref_bit, i_run, i_clr,
    input  o_ber_samp, o_ber_error, o_latency, o_aligned, o_searching
  );

  modport slave (
    input  i_enb, i_rx_bit, i_ref_bit, i_run, i_clr,
    output o_ber_samp, o_ber_error, o_latency, o_aligned, o_searching
  );
endinterface

// File: rtl/ber_counter.sv
// Per-channel BER counter: searches the rx-to-reference latency with fewest errors, then counts.
// Latency: counters, latency and status flags are registered and update the cycle after a strobe.
// Backpressure: none; every i_enb strobe is consumed; counters saturate instead of wrapping.
module ber_counter #(
  parameter int NB_CNT  = 64,
  parameter int MAX_LAT = 511,
  parameter int NB_LAT  = 9,
  parameter int WINDOW  = 64
) (
  input  logic          clk,
  input  logic          i_rst,
  ber_counter_if.slave  bus
);

  localparam int                NB_WIN   = $clog2(WINDOW + 1);
  localparam logic [NB_WIN-1:0] WIN_LAST = NB_WIN'(WINDOW - 1);
  localparam logic [NB_LAT-1:0] LAT_LAST = NB_LAT'(MAX_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_COUNT} state_t;

  state_t              state_q, state_d;
  logic [MAX_LAT-2:0]  ref_sr_q, ref_sr_d;
  logic [NB_LAT-1:0]   lat_q, lat_d;
  logic [NB_LAT-1:0]   best_lat_q, best_lat_d;
  logic [NB_LAT-1:0]   latency_q, latency_d;
  logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
  logic [NB_WIN-1:0]   win_err_q, win_err_d;
  logic [NB_WIN-1:0]   min_err_q, min_err_d;
  logic [NB_CNT-1:0]   samp_q, samp_d;
  logic [NB_CNT-1:0]   err_q, err_d;

  // Candidate vector: bit L is the reference bit from L strobes ago (bit 0 = this strobe).
  logic [MAX_LAT-1:0]  cand;
  logic                miss_srch;
  logic                miss_cnt;
  logic [NB_WIN-1:0]   win_err_nxt;
  logic                new_min;

  assign cand        = {ref_sr_q, bus.i_ref_bit};
  assign miss_srch   = bus.i_rx_bit ^ cand[lat_q];
  assign miss_cnt    = bus.i_rx_bit ^ cand[latency_q];
  assign win_err_nxt = win_err_q + NB_WIN'(miss_srch);
  // Strict compare so that on a tie the earlier (lower) latency is kept.
  assign new_min     = (win_err_nxt < min_err_q);

  // Next-state, search bookkeeping and counter updates.
  always_comb begin
    state_d    = state_q;
    ref_sr_d   = ref_sr_q;
    lat_d      = lat_q;
    best_lat_d = best_lat_q;
    latency_d  = latency_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    min_err_d  = min_err_q;
    samp_d     = samp_q;
    err_d      = err_q;

    // The reference history runs in every state so it is primed before any search.
    if (bus.i_enb) begin
      ref_sr_d = cand[MAX_LAT-2:0];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_run) begin
          state_d    = ST_SEARCH;
          samp_d     = '0;
          err_d      = '0;
          lat_d      = '0;
          win_cnt_d  = '0;
          win_err_d  = '0;
          min_err_d  = '1;
          best_lat_d = '0;
        end
      end

      ST_SEARCH: begin
        if (!bus.i_run) begin
          state_d = ST_IDLE;
        end else if (bus.i_enb) begin
          if (win_cnt_q == WIN_LAST) begin
            if (win_err_nxt == '0) begin
              latency_d = lat_q;
              state_d   = ST_COUNT;
            end else begin
              if (new_min) begin
                min_err_d  = win_err_nxt;
                best_lat_d = lat_q;
              end
              if (lat_q == LAT_LAST) begin
                latency_d = new_min ? lat_q : best_lat_q;
                state_d   = ST_COUNT;
              end else begin
                lat_d     = lat_q + NB_LAT'(1);
                win_cnt_d = '0;
                win_err_d = '0;
              end
            end
          end else begin
            win_cnt_d = win_cnt_q + NB_WIN'(1);
            win_err_d = win_err_nxt;
          end
        end
      end

      ST_COUNT: begin
        if (!bus.i_run) begin
          state_d = ST_IDLE;
        end else if (bus.i_clr) begin
          // A clear coincident with a strobe wins; that strobe is dropped.
          samp_d = '0;
          err_d  = '0;
        end else if (bus.i_enb) begin
          if (samp_q != '1) samp_d = samp_q + NB_CNT'(1);
          if (miss_cnt && (err_q != '1)) err_d = err_q + NB_CNT'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ref_sr_q   <= '0;
      lat_q      <= '0;
      best_lat_q <= '0;
      latency_q  <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      min_err_q  <= '1;
      samp_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ref_sr_q   <= ref_sr_d;
      lat_q      <= lat_d;
      best_lat_q <= best_lat_d;
      latency_q  <= latency_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      min_err_q  <= min_err_d;
      samp_q     <= samp_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_ber_samp  = samp_q;
  assign bus.o_ber_error = err_q;
  assign bus.o_latency   = latency_q;
  assign bus.o_aligned   = (state_q == ST_COUNT);
  assign bus.o_searching = (state_q == ST_SEARCH);

endmodule

// File: tb/tb_ber_counter.sv
// Bench for ber_counter: a full-size instance (PRBS9, delay 5) and a small one (8 lats, 4-bit counters).
// Expected values come from recorded strobe histories: per-window error sums and saturating counts.
// Inputs are driven just after the rising edge and outputs sampled 1 time unit after it.
module tb_ber_counter;

  localparam int A_CNT = 64, A_MAX = 511, A_LAT = 9, A_WIN = 64;
  localparam int B_CNT = 4,  B_MAX = 8,   B_LAT = 3, B_WIN = 16;
  localparam int M_DLY = 0, M_ZERO = 1, M_INV = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ber_counter_if #(.NB_CNT(A_CNT), .NB_LAT(A_LAT)) bus_a ();
  ber_counter_if #(.NB_CNT(B_CNT), .NB_LAT(B_LAT)) bus_b ();

  ber_counter #(.NB_CNT(A_CNT), .MAX_LAT(A_MAX), .NB_LAT(A_LAT), .WINDOW(A_WIN))
    dut_a (.clk(clk), .i_rst(rst), .bus(bus_a));
  ber_counter #(.NB_CNT(B_CNT), .MAX_LAT(B_MAX), .NB_LAT(B_LAT), .WINDOW(B_WIN))
    dut_b (.clk(clk), .i_rst(rst), .bus(bus_b));

  int   n_chk = 0;
  int   n_err = 0;
  bit   ra_h[$], fa_h[$], rb_h[$], fb_h[$];
  logic [8:0] prbs;
  bit   run_a, run_b;
  int   mode, dly, inj_per, noise, ph_n;
  bit   gaps;
  int   lock_lat[2];
  int   cnt_start[2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int hsize(input int sel);
    return (sel == 0) ? ra_h.size() : rb_h.size();
  endfunction

  function automatic bit ref_at(input int sel, input int i);
    if (i < 0) return 1'b0;
    return (sel == 0) ? fa_h[i] : fb_h[i];
  endfunction

  function automatic bit rx_at(input int sel, input int i);
    return (sel == 0) ? ra_h[i] : rb_h[i];
  endfunction

  function automatic logic [63:0] o_samp(input int sel);
    return (sel == 0) ? bus_a.o_ber_samp : 64'(bus_b.o_ber_samp);
  endfunction
  function automatic logic [63:0] o_errs(input int sel);
    return (sel == 0) ? bus_a.o_ber_error : 64'(bus_b.o_ber_error);
  endfunction
  function automatic logic [63:0] o_lat(input int sel);
    return (sel == 0) ? 64'(bus_a.o_latency) : 64'(bus_b.o_latency);
  endfunction
  function automatic logic [63:0] o_al(input int sel);
    return (sel == 0) ? 64'(bus_a.o_aligned) : 64'(bus_b.o_aligned);
  endfunction
  function automatic logic [63:0] o_se(input int sel);
    return (sel == 0) ? 64'(bus_a.o_searching) : 64'(bus_b.o_searching);
  endfunction

  task automatic check_outs(input int sel, input string tag, input longint unsigned s,
                            input longint unsigned e, input int lat, input bit al, input bit se);
    check_val({tag, ".samp"}, o_samp(sel), 64'(s));
    check_val({tag, ".err"},  o_errs(sel), 64'(e));
    check_val({tag, ".lat"},  o_lat(sel),  64'(lat));
    check_val({tag, ".aligned"},   o_al(sel), 64'(al));
    check_val({tag, ".searching"}, o_se(sel), 64'(se));
  endtask

  // One clock cycle: present inputs, take the edge, record the strobe if one was given.
  task automatic drive(input int sel, input bit enb, input bit rx, input bit rf, input bit clr);
    bus_a.i_run     = run_a;
    bus_b.i_run     = run_b;
    bus_a.i_enb     = (sel == 0) && enb;
    bus_b.i_enb     = (sel == 1) && enb;
    bus_a.i_clr     = (sel == 0) && clr;
    bus_b.i_clr     = (sel == 1) && clr;
    bus_a.i_rx_bit  = rx;
    bus_b.i_rx_bit  = rx;
    bus_a.i_ref_bit = rf;
    bus_b.i_ref_bit = rf;
    @(posedge clk);
    #1;
    if (enb && !rst) begin
      if (sel == 0) begin ra_h.push_back(rx); fa_h.push_back(rf); end
      else          begin rb_h.push_back(rx); fb_h.push_back(rf); end
    end
  endtask

  task automatic idle_cyc(input int sel);
    drive(sel, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic set_run(input int sel, input bit r);
    if (sel == 0) run_a = r; else run_b = r;
    idle_cyc(sel);
  endtask

  // Next reference bit and the rx bit the current stimulus mode derives from it.
  task automatic gen_bits(input int sel, output bit rx, output bit rf);
    int n;
    int k;
    n = hsize(sel);
    if (sel == 0) begin
      rf   = prbs[8] ^ prbs[4];
      prbs = {prbs[7:0], rf};
    end else begin
      rf = 1'($urandom_range(0, 1));
    end
    k = (mode == M_INV) ? lock_lat[sel] : dly;
    case (mode)
      M_ZERO:  rx = 1'b0;
      M_INV:   rx = ~((k == 0) ? rf : ref_at(sel, n - k));
      default: rx = (k == 0) ? rf : ref_at(sel, n - k);
    endcase
    if (inj_per > 0 && (ph_n % inj_per) == inj_per - 1) rx = ~rx;
    if (noise > 0 && $urandom_range(0, 99) < noise) rx = ~rx;
    ph_n++;
  endtask

  task automatic strobe(input int sel);
    bit rx, rf;
    if (gaps && $urandom_range(0, 3) == 0) idle_cyc(sel);
    gen_bits(sel, rx, rf);
    drive(sel, 1'b1, rx, rf, 1'b0);
  endtask

  // Mismatches in the window evaluated for latency lat of a search starting at strobe start.
  function automatic int win_errs(input int sel, input int start, input int lat, input int w);
    int e = 0;
    for (int k = 0; k < w; k++) begin
      int s = start + lat * w + k;
      if (rx_at(sel, s) != ref_at(sel, s - lat)) e++;
    end
    return e;
  endfunction

  // Expected counters: strobes and mismatches since the last clear/lock, saturated.
  task automatic model_counts(input int sel, output longint unsigned s, output longint unsigned e);
    longint unsigned cap;
    cap = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd15;
    s = 64'(hsize(sel) - cnt_start[sel]);
    e = 0;
    for (int i = cnt_start[sel]; i < hsize(sel); i++)
      if (rx_at(sel, i) != ref_at(sel, i - lock_lat[sel])) e++;
    if (s > cap) s = cap;
    if (e > cap) e = cap;
  endtask

  task automatic check_counts(input int sel, input string tag);
    longint unsigned s, e;
    model_counts(sel, s, e);
    check_outs(sel, tag, s, e, lock_lat[sel], 1'b1, 1'b0);
  endtask

  // Drive a search; stop_lat >= 0 abandons it 10 strobes into that latency's window.
  task automatic do_search(input int sel, input int stop_lat, input int prev_lat, input string tag);
    int start, m, w, mine, best, e, exp_lat;
    start   = hsize(sel);
    m       = (sel == 0) ? A_MAX : B_MAX;
    w       = (sel == 0) ? A_WIN : B_WIN;
    mine    = 1 << 30;
    best    = 0;
    exp_lat = -1;
    for (int l = 0; l < m; l++) begin
      if (l > 0) begin
        check_val({tag, ".mid_searching"}, o_se(sel), 64'd1);
        check_val({tag, ".mid_lat_held"},  o_lat(sel), 64'(prev_lat));
      end
      if (l == stop_lat) begin
        for (int k = 0; k < 10; k++) strobe(sel);
        return;
      end
      for (int k = 0; k < w; k++) strobe(sel);
      e = win_errs(sel, start, l, w);
      if (e == 0) begin exp_lat = l; break; end
      if (e < mine) begin mine = e; best = l; end
      if (l == m - 1) exp_lat = best;
    end
    lock_lat[sel]  = exp_lat;
    cnt_start[sel] = hsize(sel);
    check_outs(sel, {tag, ".lock"}, 0, 0, exp_lat, 1'b1, 1'b0);
  endtask

  task automatic run_count(input int sel, input int n, input string tag);
    ph_n = 0;
    for (int i = 0; i < n; i++) strobe(sel);
    check_counts(sel, tag);
  endtask

  initial begin
    longint unsigned hs, he;
    bit rx, rf;
    rst = 1'b1;
    run_a = 1'b1; run_b = 1'b1;
    mode = M_DLY; dly = 5; inj_per = 0; noise = 0; ph_n = 0; gaps = 1'b0;
    prbs = 9'($urandom_range(1, 511));
    lock_lat[0] = 0; lock_lat[1] = 0; cnt_start[0] = 0; cnt_start[1] = 0;

    // Reset held with run high and strobes toggling on both instances.
    for (int i = 0; i < 6; i++) drive(i % 2, 1'b1, 1'b1, 1'b1, 1'b0);
    check_outs(0, "rst_a", 0, 0, 0, 1'b0, 1'b0);
    check_outs(1, "rst_b", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    ra_h.delete(); fa_h.delete(); rb_h.delete(); fb_h.delete();
    idle_cyc(0);
    check_val("post_rst_a.searching", o_se(0), 64'd1);
    check_val("post_rst_b.searching", o_se(1), 64'd1);
    set_run(1, 1'b0);
    check_val("b_idle.searching", o_se(1), 64'd0);

    // Clean lock on the full-size instance, strobe every cycle.
    do_search(0, -1, 0, "lock1");
    check_val("lock1.strobes", 64'(hsize(0)), 64'd384);
    gaps = 1'b1;
    run_count(0, 1000, "clean1000");

    // Plain clear, then every 100th rx bit inverted.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
    cnt_start[0] = hsize(0);
    check_counts(0, "clr_plain");
    inj_per = 100;
    run_count(0, 1000, "inject1000");
    inj_per = 0;

    // Clear coincident with an errored strobe: strobe must be dropped.
    gen_bits(0, rx, rf);
    drive(0, 1'b1, ~rx, rf, 1'b1);
    cnt_start[0] = hsize(0);
    check_counts(0, "clr_enb");

    noise = 5;
    run_count(0, 300, "noise300");
    noise = 0;

    // Run drop from COUNT: counters and latency held through IDLE strobes.
    model_counts(0, hs, he);
    set_run(0, 1'b0);
    check_outs(0, "drop_cnt", hs, he, lock_lat[0], 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) strobe(0);
    check_outs(0, "idle_hold", hs, he, lock_lat[0], 1'b0, 1'b0);

    // Restart, abandon at lat 3, restart again and relock.
    set_run(0, 1'b1);
    check_outs(0, "restart", 0, 0, lock_lat[0], 1'b0, 1'b1);
    do_search(0, 3, lock_lat[0], "partial");
    set_run(0, 1'b0);
    check_outs(0, "drop_srch", 0, 0, lock_lat[0], 1'b0, 1'b0);
    set_run(0, 1'b1);
    do_search(0, -1, lock_lat[0], "lock2");
    noise = 3;
    run_count(0, 200, "noise200");
    noise = 0;

    // Asynchronous reset mid-count.
    run_count(0, 50, "pre_rst");
    rst = 1'b1;
    #1;
    check_outs(0, "async_rst", 0, 0, 0, 1'b0, 1'b0);
    run_a = 1'b0;
    idle_cyc(0);
    rst = 1'b0;
    ra_h.delete(); fa_h.delete(); rb_h.delete(); fb_h.delete();

    // Small instance: rx stuck at 0 sweeps every window, then saturation.
    set_run(1, 1'b1);
    check_val("b_start.searching", o_se(1), 64'd1);
    mode = M_ZERO;
    do_search(1, -1, 0, "sweep");
    mode = M_INV;
    run_count(1, 20, "sat");
    check_val("sat.samp_const", o_samp(1), 64'd15);
    check_val("sat.err_const",  o_errs(1), 64'd15);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
